// File: rtl/lvds_pll_dps_pkg.sv
// Shared types and constants for the LVDS PLL dynamic-phase-shift stepper.
//   dps_state_t      : stepper FSM state encoding
//   CNTSEL_*         : PLL cntsel codes (C0, C1, all C counters, M counter)
//   timeout_width()  : bits needed by a down-counter loaded with a value up to t
package lvds_pll_dps_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ASSERT    = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    GAP       = 3'd4
  } dps_state_t;

  localparam logic [4:0] CNTSEL_C0    = 5'd0;
  localparam logic [4:0] CNTSEL_C1    = 5'd1;
  localparam logic [4:0] CNTSEL_ALL_C = 5'd15;
  localparam logic [4:0] CNTSEL_M     = 5'd18;

  function automatic int timeout_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/lvds_dps_sync.sv
// Two-flop synchronizer for a single asynchronous PLL status bit.
//   i_clk   : destination clock (scanclk)
//   i_rst_n : asynchronous active-low reset, both flops load RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output, two cycles of latency
module lvds_dps_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/lvds_pll_dps_stepper.sv
// Turns one phase-shift request (counter select, direction, step count) into
// a paced series of single dynamic-phase-shift steps on the LVDS input PLL.
// Everything runs on scanclk.
//
// Optional feature macro: LVDS_DPS_POS_TRACK_EN adds o_pos_c0/o_pos_c1, the
// net completed step count for C0 and C1 (two's-complement wrap).
//
// Ports
//   i_scanclk, i_rst_n          : clock, asynchronous active-low reset
//   i_req_valid/o_req_ready     : request handshake (ready only in IDLE while locked)
//   i_req_steps/i_req_up/i_req_cnt : step count, direction, cntsel code
//   o_busy, o_steps_left        : request in progress, steps still to issue
//   o_done, o_err               : completion pulse, sticky timeout/lock-loss flag
//   o_pll_phase_en/updn/cntsel  : PLL DPS control
//   i_pll_phase_done, i_pll_locked : PLL status (asynchronous)
//   o_pos_c0, o_pos_c1          : position trackers (macro only)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a request; ready while locked
// ASSERT    | phase_en high for EN_CYCLES cycles
// WAIT_LOW  | phase_en low, waiting for phase_done to fall (timed)
// WAIT_HIGH | waiting for phase_done to rise; step counted here (timed)
// GAP       | pacing gap, then next step or completion
module lvds_pll_dps_stepper
  import lvds_pll_dps_pkg::*;
#(
  parameter int STEP_W     = 8,
  parameter int EN_CYCLES  = 2,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
`ifdef LVDS_DPS_POS_TRACK_EN
  ,
  parameter int POS_W      = 10
`endif
) (
  input  logic              i_scanclk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [STEP_W-1:0] i_req_steps,
  input  logic              i_req_up,
  input  logic [4:0]        i_req_cnt,
  output logic              o_busy,
  output logic [STEP_W-1:0] o_steps_left,
  output logic              o_done,
  output logic              o_err,
  output logic              o_pll_phase_en,
  output logic              o_pll_updn,
  output logic [4:0]        o_pll_cntsel,
  input  logic              i_pll_phase_done,
  input  logic              i_pll_locked
`ifdef LVDS_DPS_POS_TRACK_EN
  ,
  output logic signed [POS_W-1:0] o_pos_c0,
  output logic signed [POS_W-1:0] o_pos_c1
`endif
);

  localparam int EN_W  = timeout_width(EN_CYCLES);
  localparam int GAP_W = timeout_width(GAP_CYCLES);
  localparam int TO_W  = timeout_width(TIMEOUT);

  localparam logic [EN_W-1:0]  EN_LOAD  = EN_W'(EN_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  // Loaded with TIMEOUT-1 so the terminal compare fires on the TIMEOUT-th cycle.
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);

  dps_state_t        r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_phase_en;
  logic              r_updn;
  logic [4:0]        r_cntsel;
  logic [STEP_W-1:0] r_steps_left;
  logic [EN_W-1:0]   r_en_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [TO_W-1:0]   r_to_cnt;

  logic w_done_s;
  logic w_locked_s;
  logic w_accept;
  logic w_abort;
  logic w_gap_tc;

  // phase_done idles high, so its synchronizer resets high to avoid a fake fall.
  lvds_dps_sync #(.RST_VAL(1'b1)) u_sync_done (
    .i_clk  (i_scanclk),
    .i_rst_n(i_rst_n),
    .i_d    (i_pll_phase_done),
    .o_q    (w_done_s)
  );

  lvds_dps_sync #(.RST_VAL(1'b0)) u_sync_locked (
    .i_clk  (i_scanclk),
    .i_rst_n(i_rst_n),
    .i_d    (i_pll_locked),
    .o_q    (w_locked_s)
  );

  assign o_req_ready = (r_state == IDLE) && w_locked_s;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_abort     = r_busy && !w_locked_s;
  // The cycle seeing phase_done rise counts as the first gap cycle, so the gap
  // ends at count 1; a zero load (empty request) also exits immediately.
  assign w_gap_tc    = (r_gap_cnt <= GAP_W'(1));

  always_ff @(posedge i_scanclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_phase_en   <= 1'b0;
      r_updn       <= 1'b0;
      r_cntsel     <= '0;
      r_steps_left <= '0;
      r_en_cnt     <= '0;
      r_gap_cnt    <= '0;
      r_to_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state    <= IDLE;
        r_busy     <= 1'b0;
        r_phase_en <= 1'b0;
        r_err      <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_updn       <= i_req_up;
              r_cntsel     <= i_req_cnt;
              r_steps_left <= i_req_steps;
              r_err        <= 1'b0;
              r_busy       <= 1'b1;
              if (i_req_steps == '0) begin
                r_state   <= GAP;
                r_gap_cnt <= '0;
              end else begin
                r_state    <= ASSERT;
                r_phase_en <= 1'b1;
                r_en_cnt   <= EN_LOAD;
              end
            end
          end
          ASSERT: begin
            if (r_en_cnt == '0) begin
              r_phase_en <= 1'b0;
              r_state    <= WAIT_LOW;
              r_to_cnt   <= TO_LOAD;
            end else begin
              r_en_cnt <= r_en_cnt - EN_W'(1);
            end
          end
          WAIT_LOW: begin
            if (!w_done_s) begin
              r_state  <= WAIT_HIGH;
              r_to_cnt <= TO_LOAD;
            end else if (r_to_cnt == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt - TO_W'(1);
            end
          end
          WAIT_HIGH: begin
            if (w_done_s) begin
              r_state      <= GAP;
              r_steps_left <= r_steps_left - STEP_W'(1);
              r_gap_cnt    <= GAP_LOAD;
            end else if (r_to_cnt == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_to_cnt <= r_to_cnt - TO_W'(1);
            end
          end
          GAP: begin
            if (w_gap_tc) begin
              if (r_steps_left != '0) begin
                r_state    <= ASSERT;
                r_phase_en <= 1'b1;
                r_en_cnt   <= EN_LOAD;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy         = r_busy;
  assign o_steps_left   = r_steps_left;
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_pll_phase_en = r_phase_en;
  assign o_pll_updn     = r_updn;
  assign o_pll_cntsel   = r_cntsel;

`ifdef LVDS_DPS_POS_TRACK_EN
  logic                    w_step_done;
  logic                    w_hit_c0;
  logic                    w_hit_c1;
  logic signed [POS_W-1:0] w_delta;
  logic signed [POS_W-1:0] r_pos_c0;
  logic signed [POS_W-1:0] r_pos_c1;

  // Same condition as the WAIT_HIGH -> GAP transition; aborted steps never count.
  assign w_step_done = (r_state == WAIT_HIGH) && w_done_s && !w_abort;
  assign w_hit_c0    = (r_cntsel == CNTSEL_C0) || (r_cntsel == CNTSEL_ALL_C);
  assign w_hit_c1    = (r_cntsel == CNTSEL_C1) || (r_cntsel == CNTSEL_ALL_C);
  assign w_delta     = r_updn ? POS_W'(1) : '1;

  always_ff @(posedge i_scanclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos_c0 <= '0;
      r_pos_c1 <= '0;
    end else if (w_step_done) begin
      if (w_hit_c0) r_pos_c0 <= r_pos_c0 + w_delta;
      if (w_hit_c1) r_pos_c1 <= r_pos_c1 + w_delta;
    end
  end

  assign o_pos_c0 = r_pos_c0;
  assign o_pos_c1 = r_pos_c1;
`endif

endmodule

// File: tb/tb_lvds_pll_dps_stepper.sv
// Self-checking bench for lvds_pll_dps_stepper with a behavioural PLL DPS model.
// Position checks are active when LVDS_DPS_POS_TRACK_EN is defined.
module tb_lvds_pll_dps_stepper;

  localparam logic [4:0] C0  = 5'd0;
  localparam logic [4:0] C1  = 5'd1;
  localparam logic [4:0] CA  = 5'd15;
  localparam logic [4:0] CM  = 5'd18;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_steps = '0;
  logic       req_up = 1'b0;
  logic [4:0] req_cnt = '0;
  logic       busy;
  logic [7:0] steps_left;
  logic       done;
  logic       err;
  logic       phase_en;
  logic       updn;
  logic [4:0] cntsel;
  logic       pd = 1'b1;
  logic       locked = 1'b1;
`ifdef LVDS_DPS_POS_TRACK_EN
  logic signed [9:0] pos_c0;
  logic signed [9:0] pos_c1;
`endif

  lvds_pll_dps_stepper dut (
    .i_scanclk       (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_steps     (req_steps),
    .i_req_up        (req_up),
    .i_req_cnt       (req_cnt),
    .o_busy          (busy),
    .o_steps_left    (steps_left),
    .o_done          (done),
    .o_err           (err),
    .o_pll_phase_en  (phase_en),
    .o_pll_updn      (updn),
    .o_pll_cntsel    (cntsel),
    .i_pll_phase_done(pd),
    .i_pll_locked    (locked)
`ifdef LVDS_DPS_POS_TRACK_EN
    ,
    .o_pos_c0        (pos_c0),
    .o_pos_c1        (pos_c1)
`endif
  );

  always #5 clk = ~clk;

  // PLL model: phase_done falls 3 cycles after a phase_en rise, rises 5 later.
  logic m_stuck = 1'b0;
  logic m_en_d = 1'b0;
  int   m_dly = 0;
  int   m_low = 0;
  always @(negedge clk) begin
    if (phase_en && !m_en_d && !m_stuck) m_dly <= 3;
    else if (m_dly > 0) begin
      m_dly <= m_dly - 1;
      if (m_dly == 1) begin pd <= 1'b0; m_low <= 5; end
    end else if (m_low > 0) begin
      m_low <= m_low - 1;
      if (m_low == 1) pd <= 1'b1;
    end
    m_en_d <= phase_en;
  end

  // Monitors
  logic       exp_updn = 1'b0;
  logic [4:0] exp_cnt = '0;
  int n_pulse = 0, n_done = 0, n_badw = 0, n_badctl = 0, n_acc = 0, mon_w = 0;
  logic mon_en_d = 1'b0;
  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (busy && (updn !== exp_updn || cntsel !== exp_cnt)) n_badctl <= n_badctl + 1;
    if (phase_en) begin
      if (!mon_en_d) n_pulse <= n_pulse + 1;
      mon_w <= mon_w + 1;
    end else begin
      if (mon_en_d && mon_w != 2) n_badw <= n_badw + 1;
      mon_w <= 0;
    end
    mon_en_d <= phase_en;
  end
  always @(posedge clk) if (req_valid && req_ready) n_acc <= n_acc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_req(input int steps, input logic up, input logic [4:0] cnt);
    int k;
    exp_updn = up;
    exp_cnt  = cnt;
    @(negedge clk);
    req_steps = 8'(steps);
    req_up    = up;
    req_cnt   = cnt;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    chk("req_ready_wait_expired", longint'(k >= 50), 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < budget) begin @(negedge clk); k++; end
    chk("idle_wait_expired", longint'(k >= budget), 0);
    @(negedge clk);
  endtask

  typedef struct {
    int         steps;
    logic       up;
    logic [4:0] cnt;
    int         pulses;
    int         pos0;
    int         pos1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p0, d0, w0, c0, a0, k, rises;
    logic prev;

    vecs[0] = '{3, 1'b1, C1, 3,  0, 3};
    vecs[1] = '{0, 1'b0, C0, 0,  0, 3};
    vecs[2] = '{4, 1'b1, C0, 4,  4, 3};
    vecs[3] = '{6, 1'b0, C0, 6, -2, 3};
    vecs[4] = '{2, 1'b0, CA, 2, -4, 1};
    vecs[5] = '{1, 1'b1, CM, 1, -4, 1};
    vecs[6] = '{5, 1'b1, C1, 5, -4, 6};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_phase_en", phase_en, 0);
    chk("rst_steps_left", steps_left, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_updn_cntsel", {updn, cntsel}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_1_cycle", req_ready, 0);
    @(negedge clk);
    chk("ready_after_2_cycles", req_ready, 1);

    // Zero-step request: busy one cycle, done the cycle after accept
    d0 = n_done; p0 = n_pulse;
    do_req(0, 1'b0, C1);
    chk("zero_busy_c1", busy, 1);
    chk("zero_done_c1", done, 0);
    @(posedge clk); #1;
    chk("zero_busy_c2", busy, 0);
    chk("zero_done_c2", done, 1);
    @(posedge clk); #1;
    chk("zero_done_c3", done, 0);
    @(negedge clk);
    chk("zero_done_count", n_done - d0, 1);
    chk("zero_pulses", n_pulse - p0, 0);

    // Table of full requests
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      p0 = n_pulse; d0 = n_done; w0 = n_badw; c0 = n_badctl; a0 = n_acc;
      do_req(vecs[i].steps, vecs[i].up, vecs[i].cnt);
      if (vecs[i].steps != 0) begin
        // A competing request held while busy must be ignored.
        req_steps = 8'd7; req_up = ~vecs[i].up; req_cnt = 5'd3; req_valid = 1'b1;
        repeat (8) @(negedge clk);
        req_valid = 1'b0;
      end
      wait_idle(2000);
      chk($sformatf("v%0d_pulses", i), n_pulse - p0, vecs[i].pulses);
      chk($sformatf("v%0d_pulse_width_errs", i), n_badw - w0, 0);
      chk($sformatf("v%0d_updn_cntsel_errs", i), n_badctl - c0, 0);
      chk($sformatf("v%0d_done_count", i), n_done - d0, 1);
      chk($sformatf("v%0d_accepts", i), n_acc - a0, 1);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_steps_left", i), steps_left, 0);
      chk($sformatf("v%0d_ready", i), req_ready, 1);
`ifdef LVDS_DPS_POS_TRACK_EN
      chk($sformatf("v%0d_pos_c0", i), pos_c0, vecs[i].pos0);
      chk($sformatf("v%0d_pos_c1", i), pos_c1, vecs[i].pos1);
`endif
    end

    // Timeout: phase_done never falls
    m_stuck = 1'b1;
    d0 = n_done;
    do_req(3, 1'b1, C0);
    chk("to_phase_en_after_accept", phase_en, 1);
    k = 0;
    @(negedge clk);
    while (phase_en && k < 10) begin @(negedge clk); k++; end
    chk("to_phase_en_fall_expired", longint'(k >= 10), 0);
    repeat (254) @(negedge clk);
    chk("to_err_before", err, 0);
    chk("to_busy_before", busy, 1);
    @(negedge clk);
    chk("to_err_at", err, 1);
    chk("to_busy_at", busy, 0);
    chk("to_steps_left", steps_left, 3);
    chk("to_ready", req_ready, 1);
    m_stuck = 1'b0;
    repeat (10) @(negedge clk);
    chk("to_err_sticky", err, 1);
    chk("to_no_done", n_done - d0, 0);
`ifdef LVDS_DPS_POS_TRACK_EN
    chk("to_pos_c0", pos_c0, -4);
`endif

    // Lock loss in the middle of a 5-step request
    d0 = n_done;
    do_req(5, 1'b0, CM);
    chk("ll_err_cleared_on_accept", err, 0);
    rises = 0; prev = 1'b0; k = 0;
    while (rises < 2 && k < 300) begin
      @(negedge clk);
      if (phase_en && !prev) rises++;
      prev = phase_en;
      k++;
    end
    chk("ll_second_step_expired", longint'(k >= 300), 0);
    locked = 1'b0;
    repeat (2) @(negedge clk);
    chk("ll_busy_before_abort", busy, 1);
    @(negedge clk);
    chk("ll_phase_en", phase_en, 0);
    chk("ll_err", err, 1);
    chk("ll_busy", busy, 0);
    chk("ll_ready", req_ready, 0);
    a0 = n_acc; k = 0;
    req_steps = 8'd1; req_up = 1'b1; req_cnt = C1; req_valid = 1'b1;
    repeat (10) begin @(negedge clk); if (req_ready || busy) k++; end
    req_valid = 1'b0;
    chk("ll_blocked_cycles", k, 0);
    chk("ll_no_accept", n_acc - a0, 0);
    chk("ll_no_done", n_done - d0, 0);
    locked = 1'b1;
    @(negedge clk);
    chk("ll_relock_ready_1", req_ready, 0);
    @(negedge clk);
    chk("ll_relock_ready_2", req_ready, 1);
    repeat (10) @(negedge clk);

    // Request after relock clears err and completes
    d0 = n_done; p0 = n_pulse;
    do_req(1, 1'b1, C1);
    chk("rl_err_cleared", err, 0);
    wait_idle(500);
    chk("rl_done", n_done - d0, 1);
    chk("rl_pulses", n_pulse - p0, 1);
    chk("rl_err", err, 0);
`ifdef LVDS_DPS_POS_TRACK_EN
    chk("rl_pos_c1", pos_c1, 7);
`endif

    // Asynchronous reset while in ASSERT
    do_req(3, 1'b1, C0);
    @(negedge clk);
    chk("ar_phase_en_before", phase_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_phase_en", phase_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    chk("ar_steps_left", steps_left, 0);
`ifdef LVDS_DPS_POS_TRACK_EN
    chk("ar_pos", {pos_c0, pos_c1}, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

endmodule
